// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control encodings, memory access sizes and
// the default data-memory depth.
package mips_pkg;

    // ALU control encodings driven by the ALU decoder.
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    // Load/store access size carried on MemSize.
    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    // Default number of 32-bit words in the data memory (power of two).
    localparam int DEFAULT_DEPTH_WORDS = 256;

endpackage

// File: rtl/data_mem_load_extend.sv
// Load lane select and sign/zero extension for byte, halfword and word loads.
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane (little-endian) and extend it to 32 bits.
    always_comb begin
        shifted   = word >> {offset, 3'b000};
        byte_lane = shifted[7:0];
        half_lane = offset[1] ? word[31:16] : word[15:0];
        result    = 32'h0;
        case (mem_size_e'(size))
            SIZE_BYTE: result = zero_ext ? {24'h0, byte_lane}
                                         : {{24{byte_lane[7]}}, byte_lane};
            SIZE_HALF: result = zero_ext ? {16'h0, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
            SIZE_WORD: result = word;
            default:   result = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed, little-endian data memory with zero-latency loads,
// lane-masked stores, combinational fault detection and a sticky fault flag.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    output logic [31:0] ReadData,
    output logic        AddrError,
    output logic        ErrorSticky
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] index;
    logic [1:0]       offset;
    logic             range_fault;
    logic             align_fault;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep;
    logic [31:0]      load_result;

    assign index  = Address[IDX_W+1:2];
    assign offset = Address[1:0];

    // Fault detection: out-of-range address, misalignment or illegal size,
    // only meaningful while an access is actually requested.
    always_comb begin
        range_fault = |Address[31:IDX_W+2];
        align_fault = 1'b0;
        case (mem_size_e'(MemSize))
            SIZE_BYTE: align_fault = 1'b0;
            SIZE_HALF: align_fault = offset[0];
            SIZE_WORD: align_fault = |offset;
            default:   align_fault = 1'b1;
        endcase
        AddrError = (MemRead | MemWrite) & (range_fault | align_fault);
    end

    load_extend u_load_extend (
        .word     (mem[index]),
        .offset   (offset),
        .size     (MemSize),
        .zero_ext (MemUnsigned),
        .result   (load_result)
    );

    // Loads are combinational and forced to zero when idle or faulting.
    assign ReadData = (MemRead && !AddrError) ? load_result : 32'h0;

    // Store byte enables and replication of the store data onto every lane.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = 32'h0;
        case (mem_size_e'(MemSize))
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << offset;
                wdata_rep = {4{WriteData[7:0]}};
            end
            SIZE_HALF: begin
                byte_en   = 4'b0011 << {offset[1], 1'b0};
                wdata_rep = {2{WriteData[15:0]}};
            end
            SIZE_WORD: begin
                byte_en   = 4'b1111;
                wdata_rep = WriteData;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = 32'h0;
            end
        endcase
    end

    // Array update: reset clears every word and wins over a concurrent store;
    // otherwise a non-faulting store writes only its enabled lanes.
    // NOTE: the array is cleared on reset because loads after reset must read
    // zero; this makes it flops rather than a RAM macro, which is intended.
    // NOTE: non-blocking assignments so a same-cycle load sees the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (MemWrite && !AddrError) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[index][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Sticky fault flag: set after any faulting cycle, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ErrorSticky <= 1'b0;
        end else if (AddrError) begin
            ErrorSticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] ReadData;
    logic        AddrError;
    logic        ErrorSticky;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SX = 2'b11;

    data_mem #(.DEPTH_WORDS(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .Address     (Address),
        .WriteData   (WriteData),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemSize     (MemSize),
        .MemUnsigned (MemUnsigned),
        .ReadData    (ReadData),
        .AddrError   (AddrError),
        .ErrorSticky (ErrorSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one access and let the combinational outputs settle mid-cycle.
    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        MemRead     = rd;
        MemWrite    = wr;
        MemSize     = sz;
        MemUnsigned = uns;
        Address     = addr;
        WriteData   = wd;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, SW, 1'b0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_sticky", {31'h0, ErrorSticky}, 32'h0);
        drive(1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0);
        check("rst_lw10", ReadData, 32'h0);
        check("rst_aerr", {31'h0, AddrError}, 32'h0);

        // No access -> no fault even with a bad address/size
        drive(1'b0, 1'b0, SX, 1'b0, 32'h13, 32'h0);
        check("idle_aerr", {31'h0, AddrError}, 32'h0);

        // Word store/load
        drive(1'b0, 1'b1, SW, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw10_aerr", {31'h0, AddrError}, 32'h0);
        step();
        drive(1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0);
        check("lw10", ReadData, 32'hDEADBEEF);
        check("lw10_aerr", {31'h0, AddrError}, 32'h0);
        drive(1'b0, 1'b0, SW, 1'b0, 32'h10, 32'h0);
        check("noread_zero", ReadData, 32'h0);

        // Byte lanes and extension
        drive(1'b0, 1'b1, SB, 1'b0, 32'h21, 32'h000000F0);
        step();
        drive(1'b1, 1'b0, SW, 1'b0, 32'h20, 32'h0);
        check("lw20", ReadData, 32'h0000F000);
        drive(1'b1, 1'b0, SB, 1'b0, 32'h21, 32'h0);
        check("lb21", ReadData, 32'hFFFFFFF0);
        drive(1'b1, 1'b0, SB, 1'b1, 32'h21, 32'h0);
        check("lbu21", ReadData, 32'h000000F0);
        drive(1'b0, 1'b1, SB, 1'b0, 32'h23, 32'h12345680);
        step();
        drive(1'b1, 1'b0, SW, 1'b0, 32'h20, 32'h0);
        check("lw20_b3", ReadData, 32'h8000F000);
        drive(1'b1, 1'b0, SB, 1'b0, 32'h23, 32'h0);
        check("lb23", ReadData, 32'hFFFFFF80);
        drive(1'b1, 1'b0, SB, 1'b0, 32'h20, 32'h0);
        check("lb20", ReadData, 32'h0);

        // Halfword
        drive(1'b0, 1'b1, SH, 1'b0, 32'h32, 32'hABCD8001);
        step();
        drive(1'b1, 1'b0, SH, 1'b0, 32'h32, 32'h0);
        check("lh32", ReadData, 32'hFFFF8001);
        drive(1'b1, 1'b0, SH, 1'b1, 32'h32, 32'h0);
        check("lhu32", ReadData, 32'h00008001);
        drive(1'b1, 1'b0, SW, 1'b0, 32'h30, 32'h0);
        check("lw30", ReadData, 32'h80010000);

        // Misaligned store: faults, leaves memory alone, sets sticky flag
        drive(1'b0, 1'b1, SW, 1'b0, 32'h13, 32'h12345678);
        check("sw13_aerr", {31'h0, AddrError}, 32'h1);
        check("sw13_sticky_pre", {31'h0, ErrorSticky}, 32'h0);
        step();
        drive(1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0);
        check("sticky_set", {31'h0, ErrorSticky}, 32'h1);
        check("lw10_kept", ReadData, 32'hDEADBEEF);

        // Out-of-range and misaligned loads
        drive(1'b1, 1'b0, SW, 1'b0, 32'h400, 32'h0);
        check("lw400_aerr", {31'h0, AddrError}, 32'h1);
        check("lw400_data", ReadData, 32'h0);
        drive(1'b1, 1'b0, SH, 1'b0, 32'h31, 32'h0);
        check("lh31_aerr", {31'h0, AddrError}, 32'h1);
        check("lh31_data", ReadData, 32'h0);
        drive(1'b1, 1'b0, SX, 1'b0, 32'h10, 32'h0);
        check("size11_aerr", {31'h0, AddrError}, 32'h1);
        check("size11_data", ReadData, 32'h0);
        drive(1'b0, 1'b1, SH, 1'b0, 32'h32, 32'h00005555);
        check("sh32_ok_aerr", {31'h0, AddrError}, 32'h0);
        MemWrite = 1'b0;

        // Read during write returns old data, new data next cycle
        drive(1'b0, 1'b1, SW, 1'b0, 32'h40, 32'h11111111);
        step();
        drive(1'b1, 1'b1, SW, 1'b0, 32'h40, 32'h22222222);
        check("rdw_old", ReadData, 32'h11111111);
        step();
        drive(1'b1, 1'b0, SW, 1'b0, 32'h40, 32'h0);
        check("rdw_new", ReadData, 32'h22222222);

        // Reset together with a store while the sticky flag is set
        check("sticky_held", {31'h0, ErrorSticky}, 32'h1);
        reset = 1'b1;
        drive(1'b0, 1'b1, SW, 1'b0, 32'h50, 32'hA5A5A5A5);
        check("rst_aerr_legal", {31'h0, AddrError}, 32'h0);
        drive(1'b0, 1'b1, SW, 1'b0, 32'h53, 32'hA5A5A5A5);
        check("rst_aerr_comb", {31'h0, AddrError}, 32'h1);
        drive(1'b0, 1'b1, SW, 1'b0, 32'h50, 32'hA5A5A5A5);
        step();
        reset = 1'b0;
        drive(1'b1, 1'b0, SW, 1'b0, 32'h50, 32'h0);
        check("rst_lw50", ReadData, 32'h0);
        check("rst_sticky_clr", {31'h0, ErrorSticky}, 32'h0);
        drive(1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0);
        check("rst_lw10_clr", ReadData, 32'h0);
        drive(1'b1, 1'b0, SW, 1'b0, 32'h40, 32'h0);
        check("rst_lw40_clr", ReadData, 32'h0);
        step();
        check("sticky_stays_clr", {31'h0, ErrorSticky}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
